// File: rtl/multiciclo_mem_port.sv
// multiciclo_mem_port
// Multi-cycle load/store port between a processor control unit and a
// request/acknowledge memory. One access is accepted at a time from IDLE and
// is checked for size and alignment. A legal access issues a registered
// memory request and waits for MemAck, giving up after TIMEOUT cycles.
// Every access ends with a one-cycle Done pulse that carries the Fault code.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   ReadMemory            load request from control
//   WriteMemory           store request from control (wins over ReadMemory)
//   Address[31:0]         byte address
//   WriteData[31:0]       store data, taken from the low bits
//   Funct3[2:0]           000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//   ReadData[31:0]        extended load result, held until the next good load
//   Busy                  stall to control
//   Done                  one-cycle completion pulse
//   Fault[1:0]            00 ok, 01 misaligned, 10 timeout, 11 illegal size
//   MemReq, MemWe         memory request / write enable
//   MemAddr[29:0]         word address (Address[31:2])
//   MemByteEn[3:0]        byte-lane enables
//   MemWdata[31:0]        lane-aligned store data
//   MemRdata[31:0]        memory read word
//   MemAck                memory completion
module multiciclo_mem_port #(
  parameter int TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ReadMemory,
  input  logic        WriteMemory,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic [2:0]  Funct3,
  output logic [31:0] ReadData,
  output logic        Busy,
  output logic        Done,
  output logic [1:0]  Fault,
  output logic        MemReq,
  output logic        MemWe,
  output logic [29:0] MemAddr,
  output logic [3:0]  MemByteEn,
  output logic [31:0] MemWdata,
  input  logic [31:0] MemRdata,
  input  logic        MemAck
);

  localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

  typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  fault_reg, fault_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        accept;

  logic [2:0]  f3_reg;
  logic [1:0]  alo_reg;
  logic        mem_we_reg;
  logic [29:0] mem_addr_reg;
  logic [3:0]  mem_be_reg;
  logic [31:0] mem_wdata_reg;
  logic [31:0] read_data_reg;

  logic        req_any;
  logic        illegal;
  logic        misaligned;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] load_ext;

  // ------------------------------------------------------------------
  // Acceptance checks, evaluated against the live request in IDLE.
  // Stores only exist in byte/half/word sizes; loads reject 011/11x.
  // ------------------------------------------------------------------
  assign req_any = ReadMemory | WriteMemory;

  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    if (WriteMemory) begin
      illegal = Funct3[2] | (Funct3[1:0] == 2'b11);
    end else begin
      illegal = (Funct3 == 3'b011) | (Funct3[2:1] == 2'b11);
    end
    misaligned = ((Funct3[1:0] == 2'b01) & Address[0]) |
                 ((Funct3[1:0] == 2'b10) & (Address[1:0] != 2'b00));
  end

  // Store lane placement; loads always fetch the whole word.
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = WriteData;
    if (WriteMemory) begin
      case (Funct3[1:0])
        2'b00: begin
          be_next    = 4'b0001 << Address[1:0];
          wdata_next = {4{WriteData[7:0]}};
        end
        2'b01: begin
          be_next    = Address[1] ? 4'b1100 : 4'b0011;
          wdata_next = {2{WriteData[15:0]}};
        end
        default: begin
          be_next    = 4'b1111;
          wdata_next = WriteData;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Load extraction from the returned word, steered by the registered
  // low address bits and size captured at acceptance.
  // ------------------------------------------------------------------
  logic [7:0] rd_byte [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign rd_byte[gi] = MemRdata[8*gi +: 8];
    end
  endgenerate

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign sel_byte = rd_byte[alo_reg];
  assign sel_half = alo_reg[1] ? MemRdata[31:16] : MemRdata[15:0];

  always_comb begin
    load_ext = MemRdata;
    case (f3_reg)
      3'b000:  load_ext = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  load_ext = {{16{sel_half[15]}}, sel_half};
      3'b100:  load_ext = {24'h000000, sel_byte};
      3'b101:  load_ext = {16'h0000, sel_half};
      default: load_ext = MemRdata;
    endcase
  end

  // ------------------------------------------------------------------
  // FSM next state
  // ------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    fault_next = fault_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_any) begin
          cnt_next = 8'd0;
          if (illegal) begin
            state_next = ERR;
            fault_next = 2'b11;
          end else if (misaligned) begin
            state_next = ERR;
            fault_next = 2'b01;
          end else begin
            state_next = REQ;
            fault_next = 2'b00;
            accept     = 1'b1;
          end
        end
      end
      REQ: begin
        if (MemAck) begin
          state_next = RESP;
          fault_next = 2'b00;
        end else if (cnt_reg + 8'd1 == TIMEOUT_CNT) begin
          // The cycle that just ended was the TIMEOUT-th request cycle.
          state_next = ERR;
          fault_next = 2'b10;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      RESP:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // Registers
  // ------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      fault_reg     <= 2'b00;
      cnt_reg       <= 8'd0;
      f3_reg        <= 3'b000;
      alo_reg       <= 2'b00;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= 30'd0;
      mem_be_reg    <= 4'b0000;
      mem_wdata_reg <= 32'd0;
      read_data_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      fault_reg <= fault_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        f3_reg        <= Funct3;
        alo_reg       <= Address[1:0];
        mem_we_reg    <= WriteMemory;
        mem_addr_reg  <= Address[31:2];
        mem_be_reg    <= be_next;
        mem_wdata_reg <= wdata_next;
      end
      // The extended result is stored on the acknowledging edge so that it
      // is already valid during the RESP cycle alongside Done.
      if ((state_reg == REQ) && MemAck && !mem_we_reg) begin
        read_data_reg <= load_ext;
      end
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign MemReq    = (state_reg == REQ);
  assign MemWe     = mem_we_reg;
  assign MemAddr   = mem_addr_reg;
  assign MemByteEn = mem_be_reg;
  assign MemWdata  = mem_wdata_reg;
  assign ReadData  = read_data_reg;
  assign Done      = (state_reg == RESP) | (state_reg == ERR);
  assign Fault     = Done ? fault_reg : 2'b00;
  assign Busy      = ((state_reg == IDLE) & req_any) | (state_reg == REQ);

endmodule
